// File: rtl/semaforo_pkg.sv
// Shared definitions for the multi-direction traffic light controller:
// state encoding and active-low seven-segment digit patterns (gfedcba).
package semaforo_pkg;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        GREEN  = 3'd1,
        YELLOW = 3'd2,
        PED    = 3'd3,
        FLASH  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7f;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg7(input logic [6:0] d);
        return (d > 7'd9) ? SEG_BLANK : SEG_DIGIT[d[3:0]];
    endfunction

endpackage

// File: rtl/semaforo_tick.sv
// One-cycle tick every TICK_DIV clocks, from a reloading down-counter.
module semaforo_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    // Counter starts at 0 after reset, so the first tick lands TICK_DIV cycles later.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (cnt == '0)
            cnt <= W'(TICK_DIV - 1);
        else
            cnt <= cnt - W'(1);
    end

    assign tick = (cnt == W'(1));

endmodule

// File: rtl/semaforo_multi.sv
// Multi-direction traffic light sequencer with pedestrian windows,
// night flashing mode and a two-digit countdown display.
//
// state  | meaning
// ALLRED | every vehicle lamp red, clearance between phases
// GREEN  | direction `phase` has green
// YELLOW | direction `phase` has yellow
// PED    | all red, walk lamps for the captured requests
// FLASH  | night mode, all yellows blink on each tick
module semaforo_multi import semaforo_pkg::*; #(
    parameter int N_DIR    = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int T_GREEN  = 10,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 1,
    parameter int T_PED    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] ped_req,
    input  logic             night_mode,
    output logic [N_DIR-1:0] red,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] walk,
    output logic [1:0]       phase,
    output logic [2:0]       state,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0
);
    localparam logic [1:0] LAST = 2'(N_DIR - 1);

    logic             tick;
    state_t           st, nxt_st;
    logic [6:0]       cnt, nxt_cnt;
    logic [1:0]       nxt_phase;
    logic [N_DIR-1:0] pending, nxt_pending, walk_mask, nxt_mask, phase_oh;
    logic             flash_on, nxt_flash;
    logic [6:0]       tens, units;

    semaforo_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic logic [1:0] next_dir(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        nxt_st      = st;
        nxt_cnt     = cnt;
        nxt_phase   = phase;
        nxt_mask    = walk_mask;
        nxt_flash   = flash_on;
        nxt_pending = (st == FLASH) ? pending : (pending | ped_req);
        if (tick) begin
            case (st)
                ALLRED:
                    if (cnt == 7'd1) begin
                        if (night_mode) begin
                            nxt_st    = FLASH;
                            nxt_cnt   = 7'd0;
                            nxt_flash = 1'b1;
                        end else if (nxt_pending != '0) begin
                            nxt_st      = PED;
                            nxt_cnt     = 7'(T_PED);
                            nxt_mask    = nxt_pending;
                            nxt_pending = '0;
                        end else begin
                            nxt_st    = GREEN;
                            nxt_cnt   = 7'(T_GREEN);
                            nxt_phase = next_dir(phase);
                        end
                    end else
                        nxt_cnt = cnt - 7'd1;
                GREEN:
                    if (cnt == 7'd1 || night_mode) begin
                        nxt_st  = YELLOW;
                        nxt_cnt = 7'(T_YELLOW);
                    end else
                        nxt_cnt = cnt - 7'd1;
                YELLOW:
                    if (cnt == 7'd1) begin
                        nxt_st  = ALLRED;
                        nxt_cnt = 7'(T_ALLRED);
                    end else
                        nxt_cnt = cnt - 7'd1;
                PED:
                    // A walk window always runs to completion; night mode is honoured afterwards.
                    if (cnt == 7'd1) begin
                        if (night_mode) begin
                            nxt_st  = ALLRED;
                            nxt_cnt = 7'(T_ALLRED);
                        end else begin
                            nxt_st    = GREEN;
                            nxt_cnt   = 7'(T_GREEN);
                            nxt_phase = next_dir(phase);
                        end
                    end else
                        nxt_cnt = cnt - 7'd1;
                FLASH:
                    if (!night_mode) begin
                        nxt_st    = ALLRED;
                        nxt_cnt   = 7'(T_ALLRED);
                        nxt_phase = LAST;
                        nxt_flash = 1'b0;
                    end else
                        nxt_flash = ~flash_on;
                default: begin
                    nxt_st  = ALLRED;
                    nxt_cnt = 7'(T_ALLRED);
                end
            endcase
        end
    end

    assign phase_oh = {{(N_DIR-1){1'b0}}, 1'b1} << nxt_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ALLRED;
            cnt       <= 7'(T_ALLRED);
            phase     <= LAST;
            pending   <= '0;
            walk_mask <= '0;
            flash_on  <= 1'b0;
            red       <= '1;
            yellow    <= '0;
            green     <= '0;
            walk      <= '0;
        end else begin
            st        <= nxt_st;
            cnt       <= nxt_cnt;
            phase     <= nxt_phase;
            pending   <= nxt_pending;
            walk_mask <= nxt_mask;
            flash_on  <= nxt_flash;
            red       <= '1;
            yellow    <= '0;
            green     <= '0;
            walk      <= '0;
            case (nxt_st)
                GREEN: begin
                    red   <= ~phase_oh;
                    green <= phase_oh;
                end
                YELLOW: begin
                    red    <= ~phase_oh;
                    yellow <= phase_oh;
                end
                PED:
                    walk <= nxt_mask;
                FLASH: begin
                    red    <= '0;
                    yellow <= {N_DIR{nxt_flash}};
                end
                default: ;
            endcase
        end
    end

    assign state = st;
    assign tens  = cnt / 7'd10;
    assign units = cnt % 7'd10;
    assign HEX1  = seg7(tens);
    assign HEX0  = seg7(units);

endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 SHALL have parameter N_DIR, default 2: number of approach directions, legal range 2..4.
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per one-second tick, minimum 2.
REQ-003 SHALL have parameters T_GREEN, T_YELLOW, T_ALLRED, T_PED, defaults 10, 3, 1, 5: phase durations in ticks, each 1..99.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ped_req, input, N_DIR bits: per-direction pedestrian button, level or pulse.
REQ-007 SHALL have port night_mode, input, 1 bit: request for flashing-yellow operation.
REQ-008 SHALL have ports red, yellow, green, output, N_DIR bits each: vehicle lamps per direction, active-high.
REQ-009 SHALL have port walk, output, N_DIR bits: pedestrian walk lamps, active-high.
REQ-010 SHALL have port phase, output, 2 bits: index of the direction currently owning, or last owning, right-of-way.
REQ-011 SHALL have port state, output, 3 bits: encoded controller state.
REQ-012 SHALL have ports HEX1, HEX0, output, 7 bits each: active-low seven-segment display of the countdown, tens and units.

Function
REQ-013 SHALL generate an internal one-cycle tick pulse every TICK_DIV clk cycles; all timing advances only on tick.
REQ-014 SHALL implement states ALLRED, GREEN, YELLOW, PED, FLASH.
REQ-015 SHALL load countdown with the state's T_x on entry and decrement it on each tick; when countdown==1 and tick, SHALL leave the state on that clock edge.
REQ-016 SHALL follow this sequence: GREEN(phase) -> YELLOW(phase) -> ALLRED -> PED if pending!=0, else GREEN(phase+1).
REQ-017 SHALL go PED -> GREEN(phase+1); phase SHALL wrap from N_DIR-1 to 0.
REQ-018 SHALL drive green[phase] in GREEN and yellow[phase] in YELLOW; all other vehicle lamps SHALL be red; in ALLRED and PED all red bits SHALL be 1.
REQ-019 SHALL OR ped_req into a sticky pending register every cycle, except in FLASH.
REQ-020 SHALL, on entry to PED, capture pending into walk_mask and clear those pending bits in the same cycle.
REQ-021 SHALL drive walk=walk_mask only in PED, otherwise 0.
REQ-022 SHALL treat a ped_req arriving during PED as pending for the next PED window; it SHALL NOT extend the current window.
REQ-023 SHALL respond to night_mode=1 sampled in GREEN by going to YELLOW on the next tick, regardless of countdown.
REQ-024 SHALL, with night_mode=1, complete YELLOW and ALLRED normally, then enter FLASH instead of PED/GREEN.
REQ-025 SHALL, in FLASH, turn all red, green and walk off and toggle all yellow bits on every tick; countdown SHALL display 0.
REQ-026 SHALL go from FLASH to ALLRED (T_ALLRED) on the first tick with night_mode=0, with phase=N_DIR-1, so the next green is direction 0.
REQ-027 SHALL, when night_mode=1 in PED, complete PED then enter ALLRED then FLASH; walk SHALL never be cut short.
REQ-028 SHALL display countdown as two BCD digits on HEX1/HEX0; leading zero shown.
REQ-029 SHALL never assert green and yellow together on any direction, nor any green during walk!=0.

Reset
REQ-030 SHALL, while rst=1 at a clk edge: state=ALLRED, countdown=T_ALLRED, phase=N_DIR-1, pending=0, walk_mask=0, tick counter=0, flash toggle=0.
REQ-031 SHALL drive red=all ones, yellow=green=walk=0 from the first edge with rst=1; reset mid-phase SHALL abort the phase immediately.

Structure
REQ-032 SHALL use a shared package semaforo_pkg holding the state encoding and the 0-9 seven-segment decode constants.
REQ-033 SHALL contain one sub-module, semaforo_tick, a parametrised TICK_DIV divider producing the one-cycle tick pulse with synchronous reset.

Verification (TICK_DIV=4, N_DIR=3, defaults otherwise)
REQ-034 SHALL check: reset release, no requests -> ALLRED 4 cycles, then GREEN phase 0 for 40 cycles, YELLOW 12 cycles, ALLRED 4 cycles, GREEN phase 1; HEX shows 10 at GREEN entry.
REQ-035 SHALL check: ped_req[2] pulsed 1 cycle during GREEN phase 0 -> after the ALLRED, PED with walk=3'b100 for 20 cycles, all red=1, then GREEN phase 1.
REQ-036 SHALL check: ped_req[0] pulsed during PED -> walk is unchanged and a second PED occurs after the next ALLRED.
REQ-037 SHALL check: night_mode=1 at GREEN countdown 8 -> YELLOW at the next tick, ALLRED, then FLASH with yellow=3'b111/3'b000 alternating every 4 cycles.
REQ-038 SHALL check: night_mode=0 in FLASH -> ALLRED 4 cycles, then GREEN phase 0.
REQ-039 SHALL check: rst=1 mid-GREEN -> red=3'b111 and green=0 on the next edge; pending=0 afterwards.
